// File: rtl/req_ack_initiator.sv
// Source-side master for the blocking req/ack link: one command in flight, response returned on a valid/ready stream.
// Optional REQ timeout abort is built when REQ_ACK_TIMEOUT_EN is defined.
module req_ack_initiator #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned RDATA_W     = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [DATA_W-1:0]  cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [RDATA_W-1:0] rsp_data,
    output logic               rsp_err,
    output logic               req,
    output logic [DATA_W-1:0]  data,
    input  logic               ack,
    input  logic [RDATA_W-1:0] rdata,
    output logic               busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic                 cmd_ready_q, cmd_ready_d;
    logic                 req_q, req_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [RDATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                 busy_q, busy_d;

`ifdef REQ_ACK_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 rsp_err_q, rsp_err_d;
`else
    logic                 unused_timeout_c;
    assign unused_timeout_c = |TIMEOUT_CYC;
`endif

    // Next-state and registered-output logic; every register holds by default.
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        req_d       = req_q;
        data_d      = data_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        busy_d      = busy_q;
`ifdef REQ_ACK_TIMEOUT_EN
        cnt_d       = cnt_q;
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    data_d      = cmd_data;
                    req_d       = 1'b1;
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = S_REQ;
`ifdef REQ_ACK_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            S_REQ: begin
                // ack takes priority over a timeout expiring in the same cycle
                if (ack) begin
                    rsp_data_d  = rdata;
                    req_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RSP;
`ifdef REQ_ACK_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    req_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RSP;
                end else begin
                    cnt_d       = cnt_q + CNT_W'(1);
`endif
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            req_q       <= 1'b0;
            data_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
`ifdef REQ_ACK_TIMEOUT_EN
            cnt_q       <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            req_q       <= req_d;
            data_q      <= data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
`ifdef REQ_ACK_TIMEOUT_EN
            cnt_q       <= cnt_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign req       = req_q;
    assign data      = data_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
`ifdef REQ_ACK_TIMEOUT_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_req_ack_initiator.sv
// Self-checking bench for req_ack_initiator: directed protocol steps plus randomized traffic
// against a transaction-level reference model.
module tb_req_ack_initiator;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned RDATA_W = 32;
    localparam int unsigned TO_CYC  = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [DATA_W-1:0]  cmd_data;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [RDATA_W-1:0] rsp_data;
    logic               rsp_err;
    logic               req;
    logic [DATA_W-1:0]  data;
    logic               ack;
    logic [RDATA_W-1:0] rdata;
    logic               busy;

    int checks = 0;
    int errors = 0;

    // Reference model: what the link should look like, in terms of observable outputs.
    bit              m_ready, m_req, m_rv, m_err, m_busy;
    bit [DATA_W-1:0] m_data;
    bit [RDATA_W-1:0] m_rdata;
    int              m_wait;      // REQ cycles spent without ack
    int              m_done;      // responses delivered
    int              obs_done;

    req_ack_initiator #(
        .DATA_W     (DATA_W),
        .RDATA_W    (RDATA_W),
        .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_data (cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err),
        .req      (req),
        .data     (data),
        .ack      (ack),
        .rdata    (rdata),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string ctx);
        chk({ctx, ".cmd_ready"}, 64'(cmd_ready), 64'(m_ready));
        chk({ctx, ".req"},       64'(req),       64'(m_req));
        chk({ctx, ".data"},      64'(data),      64'(m_data));
        chk({ctx, ".rsp_valid"}, 64'(rsp_valid), 64'(m_rv));
        chk({ctx, ".rsp_data"},  64'(rsp_data),  64'(m_rdata));
        chk({ctx, ".rsp_err"},   64'(rsp_err),   64'(m_err));
        chk({ctx, ".busy"},      64'(busy),      64'(m_busy));
    endtask

    task automatic model_reset();
        m_ready = 0; m_req = 0; m_rv = 0; m_err = 0; m_busy = 0;
        m_data = '0; m_rdata = '0; m_wait = 0;
    endtask

    // Called at a negedge: check outputs, drive one cycle of inputs, advance model across the posedge.
    task automatic step(input string ctx, input bit cv, input logic [DATA_W-1:0] cd,
                        input bit ak, input logic [RDATA_W-1:0] rd, input bit rr);
        bit n_ready, n_req, n_rv, n_err, n_busy;
        bit [DATA_W-1:0] n_data;
        bit [RDATA_W-1:0] n_rdata;
        int n_wait;
        chk_all(ctx);
        cmd_valid = cv; cmd_data = cd; ack = ak; rdata = rd; rsp_ready = rr;
        n_ready = m_ready; n_req = m_req; n_rv = m_rv; n_err = m_err; n_busy = m_busy;
        n_data = m_data; n_rdata = m_rdata; n_wait = m_wait;
        if (rsp_valid && rr) obs_done++;
        if (!m_busy && !m_ready) begin
            n_ready = 1;
        end else if (!m_busy && m_ready && cv) begin
            n_ready = 0; n_req = 1; n_busy = 1; n_data = cd; n_wait = 0;
        end else if (m_req) begin
            if (ak) begin
                n_req = 0; n_rv = 1; n_rdata = rd; n_err = 0;
`ifdef REQ_ACK_TIMEOUT_EN
            end else if (m_wait + 1 == int'(TO_CYC)) begin
                n_req = 0; n_rv = 1; n_rdata = '0; n_err = 1;
`endif
            end else begin
                n_wait = m_wait + 1;
            end
        end else if (m_rv && rr) begin
            n_rv = 0; n_ready = 1; n_busy = 0; m_done++;
        end
        @(posedge clk);
        if (rst_n) begin
            m_ready = n_ready; m_req = n_req; m_rv = n_rv; m_err = n_err; m_busy = n_busy;
            m_data = n_data; m_rdata = n_rdata; m_wait = n_wait;
        end
        @(negedge clk);
    endtask

    task automatic idle(input string ctx, input int n);
        for (int i = 0; i < n; i++) step(ctx, 0, '0, 0, '0, 1);
    endtask

    // Assert reset mid-cycle; req and rsp_valid must fall without waiting for a clock edge.
    task automatic do_reset(input string ctx);
        rst_n = 1'b0;
        #1;
        chk({ctx, ".async_req"}, 64'(req),       64'd0);
        chk({ctx, ".async_rv"},  64'(rsp_valid), 64'd0);
        model_reset();
        @(negedge clk);
        idle({ctx, ".in_reset"}, 2);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 0; cmd_data = '0; ack = 0; rdata = '0; rsp_ready = 0;
        m_done = 0; obs_done = 0;
        model_reset();
        @(negedge clk);
        idle("reset", 2);
        rst_n = 1'b1;
        idle("release", 2);

        // Single transaction with ack on the third REQ cycle
        step("single.acc", 1, 32'hA5A5_0001, 0, '0, 0);
        step("single.req1", 0, '0, 0, '0, 0);
        step("single.req2", 0, '0, 0, '0, 0);
        step("single.ack", 0, '0, 1, 32'h0000_1234, 0);

        // Backpressure with a competing command and stray acks in RSP
        for (int i = 0; i < 5; i++)
            step("bp", 1, 32'hDEAD_0000 | 32'(i), (i % 2) == 0, 32'hBAD0_0000 | 32'(i), 0);
        step("bp.release", 0, '0, 0, '0, 1);

        // Stray ack while idle
        step("stray.idle", 0, '0, 1, 32'hFFFF_FFFF, 0);
        step("stray.idle2", 0, '0, 1, 32'hEEEE_EEEE, 0);

        // Reset during REQ, then a clean transaction
        step("mid.acc", 1, 32'h0BAD_CAFE, 0, '0, 0);
        step("mid.req1", 0, '0, 0, '0, 0);
        do_reset("mid");
        idle("mid.post", 2);
        step("post.acc", 1, 32'h1357_9BDF, 0, '0, 1);
        step("post.ack", 0, '0, 1, 32'h2468_ACE0, 1);
        idle("post.rsp", 2);

`ifdef REQ_ACK_TIMEOUT_EN
        // Timeout with no ack, then ack landing on the expiry cycle
        step("to.acc", 1, 32'h7777_0001, 0, '0, 0);
        for (int i = 0; i < int'(TO_CYC); i++) step("to.wait", 0, '0, 0, '0, 0);
        step("to.rsp", 0, '0, 1, 32'h5555_5555, 1);
        idle("to.idle", 1);
        step("toack.acc", 1, 32'h7777_0002, 0, '0, 0);
        for (int i = 0; i < int'(TO_CYC) - 1; i++) step("toack.wait", 0, '0, 0, '0, 0);
        step("toack.ack", 0, '0, 1, 32'h0000_ABCD, 0);
        step("toack.rsp", 0, '0, 0, '0, 1);
        idle("toack.idle", 1);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            step("rand", $urandom_range(0, 1) == 1, $urandom(), $urandom_range(0, 3) == 0,
                 $urandom(), $urandom_range(0, 2) != 0);
        idle("drain", 12);

        chk("resp_count", 64'(obs_done), 64'(m_done));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
